// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery-domain conversion blocks.
package mont_pkg;

  localparam int MONT_WIDTH  = 1040;
  localparam int MONT_STEPS  = 1040;
  localparam int MONT_STEP_W = $clog2(MONT_STEPS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    HALVE  = 2'd2
  } state_e;

endpackage

// File: rtl/mont_from_if.sv
// Request/response bundle for mont_from: operand and modulus in, result out.
interface mont_from_if
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] prime;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, a, prime, input busy, done, result);
  modport slave  (input start, a, prime, output busy, done, result);

endinterface

// File: rtl/mont_from_add_p.sv
// WIDTH+1-bit x + p; timed as a SETTLE-cycle multicycle path from x_q/p_q.
module add_p
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, x} + {1'b0, p};

endmodule

// File: rtl/mont_from.sv
// Leaves the Montgomery domain: result = a * 2^-STEPS mod prime via serial halvings.
// Optional input reduction (a < 2p) is enabled by defining MONT_FROM_INREDUCE_EN.
module mont_from
  import mont_pkg::*;
#(
  parameter int WIDTH  = MONT_WIDTH,
  parameter int STEPS  = MONT_STEPS,
  parameter int SETTLE = 16
) (
  input logic       clk,
  input logic       rst,
  mont_from_if.slave bus
);

  localparam int STEP_W = $clog2(STEPS + 1);
  localparam int SLOW_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SETTLE - 1);
  localparam logic [STEP_W-1:0] STEP_INIT = STEP_W'(STEPS);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  p_q, p_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [SLOW_W-1:0] slow_q, slow_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;

  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    half_src;
  logic [WIDTH-1:0]  x_half;
  logic              slow_last;

  add_p #(.WIDTH(WIDTH)) u_add_p (
    .x   (x_q),
    .p   (p_q),
    .sum (sum)
  );

  // Odd x: (x + p) is even, so halving the carry-extended sum is exact.
  assign half_src  = x_q[0] ? sum : {1'b0, x_q};
  assign x_half    = WIDTH'(half_src >> 1);
  assign slow_last = (slow_q == SLOW_LAST);

`ifdef MONT_FROM_INREDUCE_EN
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] x_red;
  assign diff  = {1'b0, x_q} - {1'b0, p_q};
  assign x_red = diff[WIDTH] ? x_q : diff[WIDTH-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    p_d      = p_q;
    step_d   = step_q;
    slow_d   = slow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d    = bus.a;
          p_d    = bus.prime;
          step_d = STEP_INIT;
          slow_d = '0;
          busy_d = 1'b1;
`ifdef MONT_FROM_INREDUCE_EN
          state_d = REDUCE;
`else
          state_d = HALVE;
`endif
        end
      end
`ifdef MONT_FROM_INREDUCE_EN
      REDUCE: begin
        slow_d = slow_q + SLOW_W'(1);
        if (slow_last) begin
          slow_d  = '0;
          x_d     = x_red;
          state_d = HALVE;
        end
      end
`endif
      HALVE: begin
        slow_d = slow_q + SLOW_W'(1);
        if (slow_last) begin
          slow_d = '0;
          x_d    = x_half;
          step_d = step_q - STEP_W'(1);
          if (step_q <= STEP_W'(1)) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = x_half;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      p_q      <= '0;
      step_q   <= '0;
      slow_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      p_q      <= p_d;
      step_q   <= step_d;
      slow_q   <= slow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mont_from.sv
// Directed bench for mont_from (WIDTH=8, SETTLE=4, prime=251; STEPS=8 and STEPS=1 instances).
module tb_mont_from;

`ifdef MONT_FROM_INREDUCE_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT0 = 8 * 4 + 1 + EXTRA;
  localparam int LAT1 = 1 * 4 + 1 + EXTRA;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mont_from_if #(.WIDTH(8)) bus0 ();
  mont_from_if #(.WIDTH(8)) bus1 ();

  mont_from #(.WIDTH(8), .STEPS(8), .SETTLE(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mont_from #(.WIDTH(8), .STEPS(1), .SETTLE(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic launch0(input logic [7:0] a);
    @(negedge clk);
    bus0.a     = a;
    bus0.prime = 8'd251;
    bus0.start = 1'b1;
  endtask

  // Called in the cycle where start is high; returns done cycle (-1 on timeout).
  task automatic run0(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) bus0.start = 1'b0;
      if (bus0.done) begin
        lat = n;
        if (bus0.busy) busy_ok = 1'b0;
        break;
      end
      if (!bus0.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run1(input logic [7:0] a, output int lat, output logic [7:0] res);
    @(negedge clk);
    bus1.a     = a;
    bus1.prime = 8'd251;
    bus1.start = 1'b1;
    lat = -1;
    res = 'x;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) bus1.start = 1'b0;
      if (bus1.done) begin
        lat = n;
        res = bus1.result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (bus0.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus0.busy); end
    tests++; if (bus0.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus0.done); end
    tests++; if (bus0.result !== 8'd0) begin fails++; $display("FAIL reset_result got %0d want 0", bus0.result); end
    tests++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.result !== 8'd0) begin
      fails++; $display("FAIL reset_dut1 got busy=%b done=%b result=%0d want 0/0/0", bus1.busy, bus1.done, bus1.result);
    end
  endtask

  task automatic test_basic();
    int lat; bit busy_ok;
    launch0(8'd5);
    run0(lat, busy_ok);
    tests++; if (lat !== LAT0) begin fails++; $display("FAIL basic_latency got %0d want %0d", lat, LAT0); end
    tests++; if (!busy_ok) begin fails++; $display("FAIL basic_busy_profile got bad want high until done"); end
    tests++; if (bus0.result !== 8'd1) begin fails++; $display("FAIL basic_result got %0d want 1", bus0.result); end
  endtask

  task automatic test_vectors();
    logic [7:0] av [3] = '{8'd10, 8'd0, 8'd250};
    logic [7:0] ev [3] = '{8'd2, 8'd0, 8'd50};
    int lat; bit busy_ok;
    for (int i = 0; i < 3; i++) begin
      launch0(av[i]);
      run0(lat, busy_ok);
      tests++; if (lat !== LAT0 || bus0.result !== ev[i]) begin
        fails++; $display("FAIL vec_a%0d got result=%0d lat=%0d want %0d lat=%0d", av[i], bus0.result, lat, ev[i], LAT0);
      end
      repeat (10) @(negedge clk);
      tests++; if (bus0.result !== ev[i] || bus0.done !== 1'b0) begin
        fails++; $display("FAIL hold_a%0d got result=%0d done=%b want %0d done=0", av[i], bus0.result, bus0.done, ev[i]);
      end
    end
  endtask

  task automatic test_steps1();
    int lat; logic [7:0] res;
    run1(8'd1, lat, res);
    tests++; if (res !== 8'd126 || lat !== LAT1) begin
      fails++; $display("FAIL steps1_a1 got result=%0d lat=%0d want 126 lat=%0d", res, lat, LAT1);
    end
    run1(8'd2, lat, res);
    tests++; if (res !== 8'd1 || lat !== LAT1) begin
      fails++; $display("FAIL steps1_a2 got result=%0d lat=%0d want 1 lat=%0d", res, lat, LAT1);
    end
  endtask

  task automatic test_mid_start();
    int ndone = 0; int first = -1; logic [7:0] res = 'x;
    launch0(8'd5);
    for (int n = 1; n <= LAT0 + 20; n++) begin
      @(negedge clk);
      if (n == 1) bus0.start = 1'b0;
      if (n == 10) begin bus0.a = 8'd10; bus0.start = 1'b1; end
      if (n == 11) bus0.start = 1'b0;
      if (bus0.done) begin
        ndone++;
        if (first < 0) begin first = n; res = bus0.result; end
      end
    end
    tests++; if (ndone !== 1 || first !== LAT0) begin
      fails++; $display("FAIL mid_start_done got count=%0d at=%0d want 1 at=%0d", ndone, first, LAT0);
    end
    tests++; if (res !== 8'd1) begin fails++; $display("FAIL mid_start_result got %0d want 1", res); end
  endtask

  task automatic test_back_to_back();
    int lat; bit busy_ok;
    launch0(8'd250);
    run0(lat, busy_ok);
    tests++; if (bus0.result !== 8'd50) begin fails++; $display("FAIL b2b_first got %0d want 50", bus0.result); end
    bus0.a     = 8'd5;
    bus0.start = 1'b1;
    run0(lat, busy_ok);
    tests++; if (lat !== LAT0 || bus0.result !== 8'd1 || !busy_ok) begin
      fails++; $display("FAIL b2b_second got result=%0d lat=%0d busy_ok=%0d want 1 lat=%0d busy_ok=1", bus0.result, lat, busy_ok, LAT0);
    end
  endtask

  task automatic test_rst_mid();
    int ndone = 0; int lat; bit busy_ok;
    launch0(8'd10);
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 1) bus0.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.result !== 8'd0) begin
      fails++; $display("FAIL rst_mid_outputs got busy=%b done=%b result=%0d want 0/0/0", bus0.busy, bus0.done, bus0.result);
    end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus0.done) ndone++;
    end
    tests++; if (ndone !== 0) begin fails++; $display("FAIL rst_mid_no_done got %0d pulses want 0", ndone); end
    launch0(8'd5);
    run0(lat, busy_ok);
    tests++; if (bus0.result !== 8'd1 || lat !== LAT0) begin
      fails++; $display("FAIL rst_mid_restart got result=%0d lat=%0d want 1 lat=%0d", bus0.result, lat, LAT0);
    end
  endtask

  task automatic test_reduce();
    int lat; bit busy_ok;
`ifdef MONT_FROM_INREDUCE_EN
    launch0(8'd255);
    run0(lat, busy_ok);
    tests++; if (bus0.result !== 8'd51 || lat !== 37) begin
      fails++; $display("FAIL reduce_a255 got result=%0d lat=%0d want 51 lat=37", bus0.result, lat);
    end
`else
    launch0(8'd5);
    run0(lat, busy_ok);
    tests++; if (bus0.result !== 8'd1 || lat !== 33) begin
      fails++; $display("FAIL noreduce_latency got result=%0d lat=%0d want 1 lat=33", bus0.result, lat);
    end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    bus0.start = 1'b0;
    bus0.a     = '0;
    bus0.prime = 8'd251;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.prime = 8'd251;
    test_reset();
    test_basic();
    test_vectors();
    test_steps1();
    test_mid_start();
    test_rst_mid();
    test_back_to_back();
    test_reduce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
